// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared 640x480@60 timing constants, screen bounds and counter helper
package pong_pkg;

    localparam int CLK_DIV_DEF   = 4;
    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef logic [9:0] coord_t;

    function automatic coord_t wrap_inc(input coord_t v, input coord_t last);
        return (v == last) ? '0 : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// rtl/vga_sync_if.sv - raster position and sync bundle from vga_sync to renderers
interface vga_sync_if;
    import pong_pkg::*;

    coord_t x;
    coord_t y;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   p_tick;
    logic   frame_end;

    modport master (output x, y, hsync, vsync, video_on, p_tick, frame_end);
    modport slave  (input  x, y, hsync, vsync, video_on, p_tick, frame_end);
endinterface

// File: rtl/pixel_tick_gen.sv
// rtl/pixel_tick_gen.sv - divides the system clock down to a one-clk pixel tick
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - VGA raster counters with registered, zero-latency hsync/vsync
module vga_sync
    import pong_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_sync_if.master   vga
);

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST     = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS      = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS      = coord_t'(V_DISPLAY);
    localparam coord_t HS_START   = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END     = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START   = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END     = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   tick;
    coord_t x_q, y_q, x_nx, y_nx;
    logic   hsync_q, vsync_q;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .p_tick (tick)
    );

    always_comb begin
        x_nx = x_q;
        y_nx = y_q;
        if (tick) begin
            x_nx = wrap_inc(x_q, H_LAST);
            if (x_q == H_LAST) begin
                y_nx = wrap_inc(y_q, V_LAST);
            end
        end
    end

    // Syncs decode the next-state counts so they land on the same edge as x/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            x_q     <= x_nx;
            y_q     <= y_nx;
            hsync_q <= !((x_nx >= HS_START) && (x_nx <= HS_END));
            vsync_q <= !((y_nx >= VS_START) && (y_nx <= VS_END));
        end
    end

    assign vga.x         = x_q;
    assign vga.y         = y_q;
    assign vga.hsync     = hsync_q;
    assign vga.vsync     = vsync_q;
    assign vga.p_tick    = tick;
    assign vga.video_on  = (x_q < H_VIS) && (y_q < V_VIS);
    assign vga.frame_end = tick && (x_q == H_LAST) && (y_q == V_LAST);

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter CLK_DIV SHALL default to 4 and set system clocks per pixel (100 MHz -> 25 MHz); it SHALL be at least 2.
REQ-003 Parameter H_DISPLAY SHALL default to 640 and set visible pixels per line.
REQ-004 Parameters H_FRONT, H_SYNC and H_BACK SHALL default to 16, 96 and 48 and set horizontal porch and sync widths in pixels.
REQ-005 Parameter V_DISPLAY SHALL default to 480 and set visible lines per frame.
REQ-006 Parameters V_FRONT, V_SYNC and V_BACK SHALL default to 10, 2 and 33 and set vertical porch and sync widths in lines.
REQ-007 Port clk, input, 1 bit: system clock; all state SHALL change on its rising edge only.
REQ-008 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 Port x, output, 10 bits: current horizontal pixel count, feeding the glyph and paddle renderers.
REQ-010 Port y, output, 10 bits: current vertical line count.
REQ-011 Port hsync, output, 1 bit: horizontal sync, active-low.
REQ-012 Port vsync, output, 1 bit: vertical sync, active-low.
REQ-013 Port video_on, output, 1 bit: high while (x,y) lies in the visible area.
REQ-014 Port p_tick, output, 1 bit: one-clk pulse marking each pixel advance.
REQ-015 Port frame_end, output, 1 bit: one-clk pulse on the last pixel of each frame, for game-state update.

Function
REQ-016 The divider counter SHALL count 0..CLK_DIV-1 and wrap; p_tick SHALL be high exactly when the divider equals CLK_DIV-1.
REQ-017 On a clk edge with p_tick high, x SHALL increment; at H_TOTAL-1 (default 799) it SHALL wrap to 0 and y SHALL advance on that same edge.
REQ-018 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK, and V_TOTAL SHALL equal V_DISPLAY+V_FRONT+V_SYNC+V_BACK.
REQ-019 y SHALL increment only on a horizontal wrap; at V_TOTAL-1 (default 524) it SHALL wrap to 0.
REQ-020 x and y SHALL hold their value between p_ticks.
REQ-021 hsync SHALL be a register, low exactly while x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (default 656..751), and cycle-aligned with x.
REQ-022 vsync SHALL be a register, low exactly while y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (default 490..491), and cycle-aligned with y.
REQ-023 hsync and vsync SHALL be computed from next-state counts, so there is zero latency relative to x and y.
REQ-024 video_on SHALL be combinational: (x < H_DISPLAY) AND (y < V_DISPLAY).
REQ-025 frame_end SHALL equal p_tick AND x==H_TOTAL-1 AND y==V_TOTAL-1.
REQ-026 frame_end SHALL never be high for two consecutive clks.
REQ-027 Counter arithmetic SHALL be unsigned; x and y SHALL never exceed H_TOTAL-1 and V_TOTAL-1.
REQ-028 H_TOTAL and V_TOTAL SHALL each be at most 1024.

Reset
REQ-029 Asserting rst_n low SHALL immediately clear the divider, x and y to 0, and set hsync and vsync to 1.
REQ-030 During reset, p_tick and frame_end SHALL be 0 and video_on SHALL be 1.
REQ-031 Reset asserted mid-line or mid-frame SHALL abandon the current frame with no partial sync pulse held low.
REQ-032 After deassertion, the first p_tick SHALL occur on the CLK_DIV-th rising edge.

Structure
REQ-033 The default timing constants and H_TOTAL/V_TOTAL SHALL live in shared package pong_pkg, which the renderers also use for screen bounds.
REQ-034 The divider SHALL be a sub-module pixel_tick_gen (parameter CLK_DIV; ports clk, rst_n, p_tick).
REQ-035 Counters and sync logic SHALL stay in vga_sync.

Verification
REQ-036 Reset release with defaults -> p_tick on clk edges 4, 8, 12 ...; x=1 after edge 4; y=0.
REQ-037 Run one line -> hsync falls when x becomes 656, rises when x becomes 752 (96 ticks low); x wraps 799->0 and y increments 0->1 on that same edge.
REQ-038 Run one frame -> vsync low for exactly 2 lines (y=490,491); frame_end pulses once at (799,524); next frame_end comes exactly 420000 p_ticks later.
REQ-039 Sweep visible edge -> video_on goes 1->0 as x goes 639->640 and as y goes 479->480, and returns to 1 at (0,0).
REQ-040 Assert rst_n at x=700, y=491 (both syncs low) -> same-cycle x=y=0, hsync=vsync=1, no p_tick until 4 clks after release.
REQ-041 CLK_DIV=2 -> p_tick every 2nd clk; line period 1600 clks.
